// File: rtl/pagerank_row_dot_pkg.sv
// pagerank_row_dot_pkg
//   Shared definitions for the PageRank row dot-product engine:
//   - FSM state encoding (STATE_IDLE / STATE_RUN / STATE_DONE)
//   - memory request/response message layout for the 8/32/32 format
//   - pack/unpack helpers used to build requests and split responses
//
//   Request message (77 bits, MSB first):  type[3] opaque[8] addr[32] len[2] data[32]
//   Response message (47 bits, MSB first): type[3] opaque[8] test[2] len[2] data[32]
package pagerank_row_dot_pkg;

  localparam int MEM_TYPE_NBITS   = 3;
  localparam int MEM_OPAQUE_NBITS = 8;
  localparam int MEM_ADDR_NBITS   = 32;
  localparam int MEM_DATA_NBITS   = 32;
  localparam int MEM_LEN_NBITS    = 2;
  localparam int MEM_TEST_NBITS   = 2;

  localparam int VC_MEM_REQ_MSG_NBITS  = MEM_TYPE_NBITS + MEM_OPAQUE_NBITS + MEM_ADDR_NBITS
                                       + MEM_LEN_NBITS + MEM_DATA_NBITS;
  localparam int VC_MEM_RESP_MSG_NBITS = MEM_TYPE_NBITS + MEM_OPAQUE_NBITS + MEM_TEST_NBITS
                                       + MEM_LEN_NBITS + MEM_DATA_NBITS;

  localparam logic [MEM_TYPE_NBITS-1:0] MEM_TYPE_READ = 3'd0;

  // Counters hold 0..nnodes with nnodes <= 255; the request counter doubles
  // as the opaque field, so both share the opaque width.
  localparam int CNT_NBITS = MEM_OPAQUE_NBITS;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MEM_TYPE_NBITS-1:0]   msg_type;
    logic [MEM_OPAQUE_NBITS-1:0] opaque;
    logic [MEM_ADDR_NBITS-1:0]   addr;
    logic [MEM_LEN_NBITS-1:0]    len;
    logic [MEM_DATA_NBITS-1:0]   data;
  } mem_req_msg_t;

  typedef struct packed {
    logic [MEM_TYPE_NBITS-1:0]   msg_type;
    logic [MEM_OPAQUE_NBITS-1:0] opaque;
    logic [MEM_TEST_NBITS-1:0]   test;
    logic [MEM_LEN_NBITS-1:0]    len;
    logic [MEM_DATA_NBITS-1:0]   data;
  } mem_resp_msg_t;

  function automatic logic [VC_MEM_REQ_MSG_NBITS-1:0] vc_mem_req_msg_pack(
    input logic [MEM_TYPE_NBITS-1:0]   msg_type,
    input logic [MEM_OPAQUE_NBITS-1:0] opaque,
    input logic [MEM_ADDR_NBITS-1:0]   addr,
    input logic [MEM_LEN_NBITS-1:0]    len,
    input logic [MEM_DATA_NBITS-1:0]   data
  );
    mem_req_msg_t m;
    m.msg_type = msg_type;
    m.opaque   = opaque;
    m.addr     = addr;
    m.len      = len;
    m.data     = data;
    return m;
  endfunction

  function automatic mem_resp_msg_t vc_mem_resp_msg_unpack(
    input logic [VC_MEM_RESP_MSG_NBITS-1:0] msg
  );
    return mem_resp_msg_t'(msg);
  endfunction

endpackage

// File: rtl/pagerank_row_dot_dpath.sv
// pagerank_row_dot_dpath
//   Datapath of the row dot-product engine: captured row base address and R
//   vector, request/response counters, R-entry mux selected by the response
//   opaque tag, multiplier and wrapping accumulator.
//
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     cmd_fire_i      command accepted: capture base/R, clear counters and acc
//     req_fire_i      memory request transferred this cycle
//     resp_fire_i     memory response accepted this cycle
//     cmd_addr_i      byte base address of the row
//     cmd_rvec_i      flattened R vector, entry j at [j*nbits +: nbits]
//     resp_opaque_i   opaque tag of the response (= column index)
//     resp_data_i     G[i][opaque] returned by memory
//     req_cnt_o       number of requests issued (also next opaque tag)
//     req_addr_o      address of the next request
//     req_more_o      more requests remain to be issued
//     resp_last_o     the next accepted response completes the row
//     acc_o           running dot product
module pagerank_row_dot_dpath
  import pagerank_row_dot_pkg::*;
#(
  parameter int nbits  = 32,
  parameter int nnodes = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_fire_i,
  input  logic                        req_fire_i,
  input  logic                        resp_fire_i,
  input  logic [MEM_ADDR_NBITS-1:0]   cmd_addr_i,
  input  logic [nnodes*nbits-1:0]     cmd_rvec_i,
  input  logic [MEM_OPAQUE_NBITS-1:0] resp_opaque_i,
  input  logic [nbits-1:0]            resp_data_i,
  output logic [CNT_NBITS-1:0]        req_cnt_o,
  output logic [MEM_ADDR_NBITS-1:0]   req_addr_o,
  output logic                        req_more_o,
  output logic                        resp_last_o,
  output logic [nbits-1:0]            acc_o
);

  logic [MEM_ADDR_NBITS-1:0] base_q;
  logic [nbits-1:0]          rvec_q [nnodes];
  logic [CNT_NBITS-1:0]      req_cnt_q,  req_cnt_d;
  logic [CNT_NBITS-1:0]      resp_cnt_q, resp_cnt_d;
  logic [nbits-1:0]          acc_q,      acc_d;
  logic [nbits-1:0]          rvec_sel;
  logic [nbits-1:0]          prod;

  // Base address and R are snapshotted at accept so the scheduler is free to
  // update its R registers while this row is still being processed.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      for (int j = 0; j < nnodes; j++) begin
        rvec_q[j] <= '0;
      end
    end else if (cmd_fire_i) begin
      base_q <= cmd_addr_i;
      for (int j = 0; j < nnodes; j++) begin
        rvec_q[j] <= cmd_rvec_i[j*nbits +: nbits];
      end
    end
  end

  // Select R by the response's opaque tag rather than by arrival order, so
  // responses may come back in any order. Out-of-range tags contribute 0.
  always_comb begin
    rvec_sel = '0;
    for (int j = 0; j < nnodes; j++) begin
      if (resp_opaque_i == CNT_NBITS'(j)) begin
        rvec_sel = rvec_q[j];
      end
    end
  end

  // Low nbits of the product only; the accumulator wraps modulo 2^nbits.
  assign prod = resp_data_i * rvec_sel;

  always_comb begin
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    acc_d      = acc_q;
    if (cmd_fire_i) begin
      req_cnt_d  = '0;
      resp_cnt_d = '0;
      acc_d      = '0;
    end else begin
      if (req_fire_i) begin
        req_cnt_d = req_cnt_q + 1'b1;
      end
      if (resp_fire_i) begin
        resp_cnt_d = resp_cnt_q + 1'b1;
        acc_d      = acc_q + prod;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      acc_q      <= acc_d;
    end
  end

  // Word-aligned addressing: base + 4*req_cnt.
  assign req_addr_o  = base_q + MEM_ADDR_NBITS'({req_cnt_q, 2'b00});
  assign req_cnt_o   = req_cnt_q;
  assign req_more_o  = (req_cnt_q < CNT_NBITS'(nnodes));
  assign resp_last_o = (resp_cnt_q == CNT_NBITS'(nnodes - 1));
  assign acc_o       = acc_q;

endmodule

// File: rtl/pagerank_row_dot.sv
// pagerank_row_dot
//   Computes dot(G[i], R) for one adjacency-matrix row. The row base address
//   and R vector arrive on the cmd interface; nnodes word reads are issued to
//   memory back-to-back, each response is multiplied by the R entry named by
//   its opaque tag and accumulated, and the sum is returned on result.
//
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     cmd_val/cmd_rdy             command handshake
//     cmd_addr                    byte base address of row i
//     cmd_rvec                    flattened R vector (entry j at [j*nbits +: nbits])
//     result_val/result_rdy       result handshake
//     result_data                 dot product (mod 2^nbits)
//     mem_req_msg/val/rdy         memory read requests
//     mem_resp_msg/val/rdy        memory responses
module pagerank_row_dot
  import pagerank_row_dot_pkg::*;
#(
  parameter int nbits  = 32,
  parameter int nnodes = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_val,
  output logic                             cmd_rdy,
  input  logic [31:0]                      cmd_addr,
  input  logic [nnodes*nbits-1:0]          cmd_rvec,
  output logic                             result_val,
  input  logic                             result_rdy,
  output logic [nbits-1:0]                 result_data,
  output logic [VC_MEM_REQ_MSG_NBITS-1:0]  mem_req_msg,
  output logic                             mem_req_val,
  input  logic                             mem_req_rdy,
  input  logic [VC_MEM_RESP_MSG_NBITS-1:0] mem_resp_msg,
  input  logic                             mem_resp_val,
  output logic                             mem_resp_rdy
);

  state_e state_q, state_d;

  mem_resp_msg_t             resp;
  logic                      unused_resp_fields;
  logic                      cmd_fire;
  logic                      req_fire;
  logic                      resp_fire;
  logic [CNT_NBITS-1:0]      req_cnt;
  logic [MEM_ADDR_NBITS-1:0] req_addr;
  logic                      req_more;
  logic                      resp_last;
  logic [nbits-1:0]          acc;

  assign resp = vc_mem_resp_msg_unpack(mem_resp_msg);

  // Only opaque and data matter for a read response.
  assign unused_resp_fields = ^{resp.msg_type, resp.test, resp.len};

  assign cmd_fire  = cmd_val      & cmd_rdy;
  assign req_fire  = mem_req_val  & mem_req_rdy;
  assign resp_fire = mem_resp_val & mem_resp_rdy;

  pagerank_row_dot_dpath #(
    .nbits  (nbits),
    .nnodes (nnodes)
  ) u_dpath (
    .clk           (clk),
    .reset         (reset),
    .cmd_fire_i    (cmd_fire),
    .req_fire_i    (req_fire),
    .resp_fire_i   (resp_fire),
    .cmd_addr_i    (cmd_addr),
    .cmd_rvec_i    (cmd_rvec),
    .resp_opaque_i (resp.opaque),
    .resp_data_i   (resp.data),
    .req_cnt_o     (req_cnt),
    .req_addr_o    (req_addr),
    .req_more_o    (req_more),
    .resp_last_o   (resp_last),
    .acc_o         (acc)
  );

  assign mem_req_msg = vc_mem_req_msg_pack(MEM_TYPE_READ, req_cnt, req_addr, '0, '0);
  assign result_data = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_rdy      = 1'b0;
    result_val   = 1'b0;
    mem_req_val  = 1'b0;
    mem_resp_rdy = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          state_d = STATE_RUN;
        end
      end
      STATE_RUN: begin
        mem_resp_rdy = 1'b1;
        // The counter gate caps a command at exactly nnodes requests no
        // matter how mem_req_rdy behaves.
        mem_req_val  = req_more;
        // mem_resp_rdy is 1 throughout RUN, so mem_resp_val alone marks an
        // accepted response here.
        if (mem_resp_val && resp_last) begin
          state_d = STATE_DONE;
        end
      end
      STATE_DONE: begin
        result_val = 1'b1;
        if (result_rdy) begin
          state_d = STATE_IDLE;
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

endmodule

// File: doc/pagerank_row_dot.md
Name: pagerank_row_dot

Overview:
- Compute engine fed by the PageRank scheduler.
- For one row i of the adjacency matrix G, it reads nnodes words G[i][0..nnodes-1] from memory through one test-memory port and computes dot(G[i], R).
- R is the rank vector held in the scheduler's register set, and the result is returned to the scheduler.
- Uses the standard 8/32/32 memory request/response message format, with the usual vc pack/unpack helpers.

Parameters:
- nbits, 32, data word width; must be 32 to match the memory message data field.
- nnodes, 8, row length; also the number of R entries. Must be 2..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cmd_val  input  1  command valid
- cmd_rdy  output  1  command ready
- cmd_addr  input  32  byte base address of row i
- cmd_rvec  input  nnodes*nbits  R vector, flattened; entry j is bits [j*nbits +: nbits]
- result_val  output  1  result valid
- result_rdy  input  1  result ready
- result_data  output  nbits  dot product
- mem_req_msg  output  VC_MEM_REQ_MSG_NBITS(8,32,32)  memory request
- mem_req_val  output  1  memory request valid
- mem_req_rdy  input  1  memory request ready
- mem_resp_msg  input  VC_MEM_RESP_MSG_NBITS(8,32)  memory response
- mem_resp_val  input  1  memory response valid
- mem_resp_rdy  output  1  memory response ready

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, all counters 0, accumulator 0.
  - Outputs after reset: cmd_rdy=1, result_val=0, mem_req_val=0, mem_resp_rdy=0.
- Handshakes: a transfer occurs when val && rdy at a rising edge. A val, once asserted, never drops before its transfer.
- IDLE:
  - cmd_rdy=1.
  - On cmd transfer, capture cmd_addr and cmd_rvec into registers, clear req_cnt, resp_cnt and acc, then go to RUN.
- RUN:
  - cmd_rdy=0 and mem_resp_rdy=1.
  - mem_req_val=1 while req_cnt<nnodes.
  - Request fields: type=read (0), opaque=req_cnt, addr=base+4*req_cnt, len=0, data=0.
  - req_cnt increments on each request transfer. Requests issue back-to-back, one per cycle, when mem_req_rdy=1.
- Responses:
  - Each accepted response adds data*rvec[opaque] to acc. The product is the low nbits of the product; the sum wraps modulo 2^nbits.
  - Indexing by opaque makes out-of-order responses correct.
  - resp_cnt increments on each accepted response.
  - A request and a response may transfer in the same cycle, and both counters update.
- When the response that makes resp_cnt==nnodes is accepted, go to DONE on the next edge. The last product is included in acc.
- DONE:
  - result_val=1, result_data=acc; mem_req_val=0, mem_resp_rdy=0.
  - Holds until result_rdy; then go to IDLE.
  - result_data stays stable while result_val=1 and result_rdy=0.
- Back-to-back commands: a new command can be accepted one cycle after the result transfer, with no extra bubble.
- Latency with an always-ready memory of 1-cycle latency and cmd accepted at edge 0:
  - requests at cycles 1..nnodes;
  - responses at cycles 2..nnodes+1;
  - result_val at cycle nnodes+2 (cycle 10 for nnodes=8).
- Never more than nnodes requests are issued per command, regardless of mem_req_rdy behaviour.
- Response type and test fields are ignored.
- Responses arriving in IDLE or DONE are not accepted (mem_resp_rdy=0).
- Reset mid-operation (RUN or DONE): the operation is abandoned and the block returns to reset values next cycle. Any memory response still in flight is the memory's problem; the bench flushes the memory.
- Register cmd_rvec at accept; the scheduler may change R after cmd transfer.

Decomposition:
- Shared package holds:
  - state encoding constants STATE_IDLE, STATE_RUN, STATE_DONE;
  - memory type constant MEM_TYPE_READ=3'd0;
  - request/response message width macros (already in mem-msgs).
- Natural sub-module: pagerank_row_dot_dpath, containing the base/rvec registers, counters, rvec mux, multiplier and accumulator. The FSM stays in the top-level module.
- Memory messages are built and split with the existing vc_MemReqMsgPack and vc_MemRespMsgUnpack.

Test Plan:
1. Basic row: nnodes=8, G row at 0x1000 = {1,0,1,0,1,0,1,0}, R={10,20,30,40,50,60,70,80}, memory 1-cycle and always ready -> 8 reads at 0x1000..0x101C with opaque 0..7; result_data=160 at cycle 10.
2. Backpressure: same data, mem_req_rdy toggling 1/0 and result_rdy held low 5 cycles -> exactly 8 requests, result=160 stable until accepted; cmd_rdy=0 throughout.
3. Out-of-order memory: responses returned in order 7,0,6,1,5,2,4,3 with G all ones and R=j+1 -> result=36.
4. Wrap-around: G[0]=0xFFFF_FFFF, R[0]=2, all others 0 -> result=0xFFFF_FFFE; a second command with all G=0x8000_0000 and all R=2 -> result=0.
5. Back-to-back: two commands at 0x1000 and 0x2000 with result_rdy=1 -> second cmd accepted one cycle after first result transfer; both results correct; R changed after the first accept does not affect the first result.
6. Reset in RUN after 3 requests -> next cycle cmd_rdy=1, mem_req_val=0, result_val=0; a following command returns a correct, un-polluted result.
